// File: rtl/exe_stage_unit_pkg.sv
// Shared definitions for the execute stage: ALU command codes, shift types
// and the bit positions of the NZCV flags inside the status register.
package exe_stage_unit_pkg;

  typedef enum logic [3:0] {
    CMD_NOP = 4'b0000,
    CMD_MOV = 4'b0001,
    CMD_ADD = 4'b0010,
    CMD_ADC = 4'b0011,
    CMD_SUB = 4'b0100,
    CMD_SBC = 4'b0101,
    CMD_AND = 4'b0110,
    CMD_ORR = 4'b0111,
    CMD_EOR = 4'b1000,
    CMD_MVN = 4'b1001
  } exe_cmd_e;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shift_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/exe_stage_unit_val2_gen.sv
// Second ALU operand generator: memory offset, rotated immediate or
// immediate-amount shift of Rm. Purely combinational.
module exe_val2_gen
  import exe_stage_unit_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] val_Rm_in,
  input  logic [11:0]       shift_operand_in,
  input  logic              imm_in,
  input  logic              is_mem,
  output logic [DATA_W-1:0] val2
);

  logic [DATA_W-1:0]   imm_ext;
  logic [4:0]          imm_rot;
  logic [4:0]          sh_amt;
  logic [2*DATA_W-1:0] imm_dbl;
  logic [2*DATA_W-1:0] rm_dbl;
  logic signed [DATA_W-1:0] rm_s;

  assign imm_ext = {{(DATA_W-8){1'b0}}, shift_operand_in[7:0]};
  assign imm_rot = {shift_operand_in[11:8], 1'b0};
  assign sh_amt  = shift_operand_in[11:7];
  assign rm_s    = signed'(val_Rm_in);

  // Rotations are done by shifting a doubled copy; the low half is the result.
  always_comb begin
    imm_dbl = {imm_ext, imm_ext} >> imm_rot;
    rm_dbl  = {val_Rm_in, val_Rm_in} >> sh_amt;
    val2    = val_Rm_in;
    if (is_mem) begin
      val2 = {{(DATA_W-12){1'b0}}, shift_operand_in};
    end else if (imm_in) begin
      val2 = imm_dbl[DATA_W-1:0];
    end else if (sh_amt != 5'd0) begin
      case (shift_operand_in[6:5])
        SH_LSL:  val2 = val_Rm_in << sh_amt;
        SH_LSR:  val2 = val_Rm_in >> sh_amt;
        SH_ASR:  val2 = rm_s >>> sh_amt;
        default: val2 = rm_dbl[DATA_W-1:0];
      endcase
    end
  end

endmodule

// File: rtl/exe_stage_unit.sv
// Execute stage: Val2 generation, ALU with NZCV status register, branch
// target computation and the EX/MEM pipeline register.
module exe_stage_unit
  import exe_stage_unit_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int PC_STEP = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              wb_en_in,
  input  logic              mem_read_en_in,
  input  logic              mem_write_en_in,
  input  logic              B_in,
  input  logic              S_in,
  input  logic              imm_in,
  input  logic [3:0]        exe_cmd_in,
  input  logic [DATA_W-1:0] PC_in,
  input  logic [DATA_W-1:0] val_Rn_in,
  input  logic [DATA_W-1:0] val_Rm_in,
  input  logic [11:0]       shift_operand_in,
  input  logic [23:0]       signed_imm_24_in,
  input  logic [3:0]        dest_in,
  output logic              branch_taken,
  output logic [DATA_W-1:0] branch_addr,
  output logic [3:0]        status,
  output logic              wb_en,
  output logic              mem_read_en,
  output logic              mem_write_en,
  output logic [DATA_W-1:0] alu_res,
  output logic [DATA_W-1:0] val_Rm,
  output logic [3:0]        dest
);

  // Branch offsets count instructions; scale by the instruction size.
  localparam int OFS_SH = $clog2(PC_STEP);

  // Returns {overflow, carry, sum[DATA_W-1:0]} of a + b + cin.
  function automatic logic [DATA_W+1:0] add_cv(input logic signed [DATA_W-1:0] a,
                                               input logic signed [DATA_W-1:0] b,
                                               input logic                     cin);
    logic [DATA_W:0] sum;
    logic            ovf;
    sum = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, cin};
    ovf = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
    return {ovf, sum};
  endfunction

  logic                     is_mem_p0;
  logic [DATA_W-1:0]        val2_p0;
  logic signed [DATA_W-1:0] op_a_p0;
  logic signed [DATA_W-1:0] op_b_p0;
  logic signed [DATA_W-1:0] br_ofs_p0;
  logic [DATA_W+1:0]        sum_p0;
  logic [DATA_W-1:0]        res_p0;
  logic                     c_p0;
  logic                     v_p0;
  logic                     op_ok_p0;
  logic                     flag_upd_p0;
  logic [3:0]               nzcv_p0;

  logic              wb_en_p1;
  logic              mem_read_en_p1;
  logic              mem_write_en_p1;
  logic [DATA_W-1:0] alu_res_p1;
  logic [DATA_W-1:0] val_Rm_p1;
  logic [3:0]        dest_p1;
  logic [3:0]        status_p1;

  assign is_mem_p0 = mem_read_en_in | mem_write_en_in;

  exe_val2_gen #(
    .DATA_W (DATA_W)
  ) u_val2 (
    .val_Rm_in        (val_Rm_in),
    .shift_operand_in (shift_operand_in),
    .imm_in           (imm_in),
    .is_mem           (is_mem_p0),
    .val2             (val2_p0)
  );

  // Branch target: sign-extended word offset added with 32-bit wrap-around.
  assign br_ofs_p0    = DATA_W'(signed'(signed_imm_24_in));
  assign branch_taken = B_in;
  assign branch_addr  = PC_in + DATA_W'(br_ofs_p0 <<< OFS_SH);

  assign op_a_p0 = signed'(val_Rn_in);

  // ALU: result plus next C/V; logical ops keep the current C and V.
  always_comb begin
    op_b_p0  = signed'(val2_p0);
    sum_p0   = '0;
    res_p0   = '0;
    c_p0     = status_p1[FLAG_C];
    v_p0     = status_p1[FLAG_V];
    op_ok_p0 = 1'b1;
    case (exe_cmd_in)
      CMD_MOV: res_p0 = val2_p0;
      CMD_MVN: res_p0 = ~val2_p0;
      CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC: begin
        if (exe_cmd_in == CMD_SUB || exe_cmd_in == CMD_SBC) begin
          op_b_p0 = ~signed'(val2_p0);
        end
        case (exe_cmd_in)
          CMD_ADD: sum_p0 = add_cv(op_a_p0, op_b_p0, 1'b0);
          CMD_SUB: sum_p0 = add_cv(op_a_p0, op_b_p0, 1'b1);
          default: sum_p0 = add_cv(op_a_p0, op_b_p0, status_p1[FLAG_C]);
        endcase
        res_p0 = sum_p0[DATA_W-1:0];
        c_p0   = sum_p0[DATA_W];
        v_p0   = sum_p0[DATA_W+1];
      end
      CMD_AND: res_p0 = val_Rn_in & val2_p0;
      CMD_ORR: res_p0 = val_Rn_in | val2_p0;
      CMD_EOR: res_p0 = val_Rn_in ^ val2_p0;
      default: op_ok_p0 = 1'b0;
    endcase
    nzcv_p0     = {res_p0[DATA_W-1], (res_p0 == '0), c_p0, v_p0};
    flag_upd_p0 = S_in & ~is_mem_p0 & op_ok_p0;
  end

  // ---- EX/MEM boundary ----
  // EX/MEM register: captures the instruction unless the memory stage stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_en_p1        <= 1'b0;
      mem_read_en_p1  <= 1'b0;
      mem_write_en_p1 <= 1'b0;
      alu_res_p1      <= '0;
      val_Rm_p1       <= '0;
      dest_p1         <= '0;
    end else if (!freeze) begin
      wb_en_p1        <= wb_en_in;
      mem_read_en_p1  <= mem_read_en_in;
      mem_write_en_p1 <= mem_write_en_in;
      alu_res_p1      <= res_p0;
      val_Rm_p1       <= val_Rm_in;
      dest_p1         <= dest_in;
    end
  end

  // Status register: written on the same edge as the instruction's result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      status_p1 <= '0;
    end else if (!freeze && flag_upd_p0) begin
      status_p1 <= nzcv_p0;
    end
  end

  assign wb_en        = wb_en_p1;
  assign mem_read_en  = mem_read_en_p1;
  assign mem_write_en = mem_write_en_p1;
  assign alu_res      = alu_res_p1;
  assign val_Rm       = val_Rm_p1;
  assign dest         = dest_p1;
  assign status       = status_p1;

endmodule
